conv_mac_tree: RTL

//   Parametrised, pipelined floating-point convolution window engine: TAPS products w[i]*if[i],
//   a generated registered adder tree, and cross-channel accumulation over CHANNELS windows.

---
 rtl/conv_mac_tree_if.sv | 28 ++
 rtl/conv_mac_tree.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_tree_if.sv
// Window-in / result-out stream bundle for conv_mac_tree.
// The master side is the producer of windows and the consumer of results; slave is the engine.
interface conv_mac_tree_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 25,
    parameter int CHANNELS   = 3
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [TAPS*DATA_WIDTH-1:0]    w_flat;
    logic [TAPS*DATA_WIDTH-1:0]    if_flat;
    logic [DATA_WIDTH-1:0]         bias;
    logic                          relu_en;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [$clog2(CHANNELS+1)-1:0] out_ch_cnt;

    modport master (
        output in_valid, w_flat, if_flat, bias, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_ch_cnt
    );

    modport slave (
        input  in_valid, w_flat, if_flat, bias, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_ch_cnt
    );
endinterface

// File: rtl/conv_mac_tree.sv
// Pipelined FP32 convolution window engine: TAPS products, registered pairwise adder tree,
// cross-channel accumulation with bias and optional ReLU, valid/ready result stream.
module conv_mac_tree #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 25,
    parameter int CHANNELS   = 3
) (
    input  logic            clk,
    input  logic            reset,
    conv_mac_tree_if.slave  bus
);

    // Entries at tree level k (level 0 = product registers)
    function automatic int lvl_cnt(input int k);
        int n;
        n = TAPS;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Flat index of the first entry of level k
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o = o + lvl_cnt(i);
        return o;
    endfunction

    // IEEE-754 single multiply, round-to-nearest-even, denormals flushed to zero
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] prod;
        logic [24:0] man;
        logic        guard, sticky;
        int          ex;
        logic [31:0] res;
        sign   = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        ex     = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            man    = {1'b0, prod[47:24]};
            guard  = prod[23];
            sticky = |prod[22:0];
            ex     = ex + 1;
        end else begin
            man    = {1'b0, prod[46:23]};
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        if (guard && (sticky || man[0])) man = man + 25'd1;
        if (man[24]) begin
            man = man >> 1;
            ex  = ex + 1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            res = {sign, 8'hFF, 23'h0};
        else if (a_zero || b_zero)
            res = {sign, 31'h0};
        else if (ex >= 255)
            res = {sign, 8'hFF, 23'h0};
        else if (ex <= 0)
            res = {sign, 31'h0};
        else
            res = {sign, ex[7:0], man[22:0]};
        return res;
    endfunction

    // IEEE-754 single add, round-to-nearest-even, denormals flushed to zero
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [26:0] mx, my, lost;
        logic [27:0] s;
        logic [24:0] rman;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        int          ex, d;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = int'(x[30:23]);
        d  = ex - int'(y[30:23]);
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        // guard/round/sticky bits keep the aligned shift exact enough for RNE
        if (d >= 27) begin
            my = 27'd1;
        end else if (d > 0) begin
            lost = my & ((27'd1 << d) - 27'd1);
            my   = (my >> d) | {26'd0, |lost};
        end
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s  = {1'b0, s[27:2], s[1] | s[0]};
                ex = ex + 1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            for (int unsigned i = 0; i < 26; i++) begin
                if (!s[26] && (s != '0)) begin
                    s  = s << 1;
                    ex = ex - 1;
                end
            end
        end
        rman = {1'b0, s[26:3]} + ((s[2] && (s[1] || s[0] || s[3])) ? 25'd1 : 25'd0);
        if (rman[24]) begin
            rman = rman >> 1;
            ex   = ex + 1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            res = 32'h7FC0_0000;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (a_zero && b_zero)
            res = {a[31] & b[31], 31'h0};
        else if (a_zero)
            res = b;
        else if (b_zero)
            res = a;
        else if (s == '0)
            res = 32'h0;
        else if (ex >= 255)
            res = {x[31], 8'hFF, 23'h0};
        else if (ex <= 0)
            res = {x[31], 31'h0};
        else
            res = {x[31], ex[7:0], rman[22:0]};
        return res;
    endfunction

    localparam int L     = $clog2(TAPS);
    localparam int CW    = $clog2(CHANNELS + 1);
    localparam int NODES = lvl_off(L + 1);
    localparam int ROOT  = lvl_off(L);

    logic                        ce, accept, ch0_in, last_ch;
    logic [CW-1:0]               in_ch, ch_cnt;
    logic [NODES*DATA_WIDTH-1:0] tree_q, tree_d;
    logic [L:0]                  vld_q, relu_q;
    logic [L:0][DATA_WIDTH-1:0]  bias_q;
    logic [DATA_WIDTH-1:0]       tree_sum, acc, acc_sum, out_data_q;
    logic                        out_valid_q;

    assign ce           = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && ce;
    assign ch0_in       = (in_ch == '0);
    assign bus.in_ready = ce;

    // Input-side channel position, used only to tag which window carries bias/relu_en
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            in_ch <= '0;
        else if (accept)
            in_ch <= (in_ch == CW'(CHANNELS - 1)) ? '0 : in_ch + 1'b1;
    end

    for (genvar j = 0; j < TAPS; j++) begin : g_mul
        assign tree_d[j*DATA_WIDTH +: DATA_WIDTH] =
            fp_mul(bus.w_flat[j*DATA_WIDTH +: DATA_WIDTH], bus.if_flat[j*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Fixed left-to-right pairing; an odd last entry is carried one level unchanged
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        for (genvar j = 0; j < lvl_cnt(k); j++) begin : g_node
            localparam int SRC = lvl_off(k - 1) + 2 * j;
            localparam int DST = lvl_off(k) + j;
            if (2 * j + 1 < lvl_cnt(k - 1)) begin : g_add
                assign tree_d[DST*DATA_WIDTH +: DATA_WIDTH] =
                    fp_add(tree_q[SRC*DATA_WIDTH +: DATA_WIDTH], tree_q[(SRC+1)*DATA_WIDTH +: DATA_WIDTH]);
            end else begin : g_pass
                assign tree_d[DST*DATA_WIDTH +: DATA_WIDTH] = tree_q[SRC*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tree_q <= '0;
            vld_q  <= '0;
            bias_q <= '0;
            relu_q <= '0;
        end else if (ce) begin
            tree_q <= tree_d;
            vld_q  <= {vld_q[L-1:0], accept};
            // Head holds the last channel-0 sideband so it trails every window of that filter
            bias_q <= {bias_q[L-1:0], (accept && ch0_in) ? bus.bias : bias_q[0]};
            relu_q <= {relu_q[L-1:0], (accept && ch0_in) ? bus.relu_en : relu_q[0]};
        end
    end

    assign tree_sum = tree_q[ROOT*DATA_WIDTH +: DATA_WIDTH];
    assign last_ch  = (ch_cnt == CW'(CHANNELS - 1));
    assign acc_sum  = fp_add((ch_cnt == '0) ? bias_q[L] : acc, tree_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            ch_cnt      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            out_valid_q <= 1'b0;
            if (vld_q[L]) begin
                if (last_ch) begin
                    out_data_q  <= (relu_q[L] && acc_sum[DATA_WIDTH-1]) ? '0 : acc_sum;
                    out_valid_q <= 1'b1;
                    ch_cnt      <= '0;
                end else begin
                    acc    <= acc_sum;
                    ch_cnt <= ch_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_ch_cnt = ch_cnt;

endmodule
